// File: rtl/spigot_e_if.sv
// Digit stream between the e spigot engine and its consumer.
// A digit moves on a rising clk edge where dout_valid && dout_ready (and the core's ena) are high;
// the producer holds dout_digit steady and never drops dout_valid until that transfer happens.
interface spigot_e_if;
    logic [3:0] dout_digit;
    logic       dout_valid;
    logic       dout_ready;

    modport master (output dout_digit, output dout_valid, input dout_ready);
    modport slave  (input dout_digit, input dout_valid, output dout_ready);
endinterface

// File: rtl/spigot_e_core.sv
// Mixed-radix spigot that streams the decimal digits of e over a valid/ready interface.
// SPIGOT_E_FAST_DIV_EN selects a one-cycle combinational divide instead of the 4-cycle restoring divider.
module spigot_e_core #(
    parameter int N_TERMS  = 32,
    parameter int N_DIGITS = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    spigot_e_if.master        dout,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state
);
    localparam int CW = $clog2(N_DIGITS + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEAD = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_DIV  = 3'd3;
    localparam logic [2:0] S_EMIT = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [5:0]    i_q, i_d;
    logic [9:0]    x_q, x_d;
    logic [3:0]    carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    a_q [2:N_TERMS];
    logic [5:0]    a_d [2:N_TERMS];
`ifndef SPIGOT_E_FAST_DIV_EN
    logic [1:0]    dcnt_q, dcnt_d;
    logic [3:0]    q_q, q_d;
    logic [9:0]    sub;
`endif

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        x_d     = x_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
`ifndef SPIGOT_E_FAST_DIV_EN
        dcnt_d  = dcnt_q;
        q_d     = q_q;
        sub     = 10'(i_q) << (2'd3 - dcnt_q);
`endif
        if (ena) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        for (int k = 2; k <= N_TERMS; k++) a_d[k] = 6'd1;
                        cnt_d   = '0;
                        i_d     = 6'(N_TERMS);
                        carry_d = 4'd0;
                        state_d = S_LEAD;
                    end
                end
                S_LEAD: begin
                    if (dout.dout_ready) begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    x_d     = 10'(a_q[i_q]) * 10'd10 + 10'(carry_q);
`ifndef SPIGOT_E_FAST_DIV_EN
                    dcnt_d  = 2'd0;
                    q_d     = 4'd0;
`endif
                    state_d = S_DIV;
                end
                S_DIV: begin
`ifdef SPIGOT_E_FAST_DIV_EN
                    a_d[i_q] = 6'(x_q % 10'(i_q));
                    carry_d  = 4'(x_q / 10'(i_q));
                    i_d      = i_q - 6'd1;
                    state_d  = (i_q == 6'd2) ? S_EMIT : S_LOAD;
`else
                    // Restoring step: try subtracting i shifted to the current quotient bit.
                    if (x_q >= sub) begin
                        x_d = x_q - sub;
                        q_d = {q_q[2:0], 1'b1};
                    end else begin
                        q_d = {q_q[2:0], 1'b0};
                    end
                    dcnt_d = dcnt_q + 2'd1;
                    if (dcnt_q == 2'd3) begin
                        a_d[i_q] = x_d[5:0];
                        carry_d  = q_d;
                        i_d      = i_q - 6'd1;
                        state_d  = (i_q == 6'd2) ? S_EMIT : S_LOAD;
                    end
`endif
                end
                S_EMIT: begin
                    if (dout.dout_ready) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_d == CW'(N_DIGITS)) begin
                            state_d = S_DONE;
                        end else begin
                            i_d     = 6'(N_TERMS);
                            carry_d = 4'd0;
                            state_d = S_LOAD;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            x_q     <= '0;
            carry_q <= '0;
            cnt_q   <= '0;
            a_q     <= '{default: '0};
`ifndef SPIGOT_E_FAST_DIV_EN
            dcnt_q  <= '0;
            q_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            x_q     <= x_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
`ifndef SPIGOT_E_FAST_DIV_EN
            dcnt_q  <= dcnt_d;
            q_q     <= q_d;
`endif
        end
    end

    // Outputs decode straight from state so reset clears them without waiting for a clock.
    always_comb begin
        dout.dout_digit = 4'd0;
        if (state_q == S_LEAD)      dout.dout_digit = 4'd2;
        else if (state_q == S_EMIT) dout.dout_digit = carry_q;
    end

    assign dout.dout_valid = (state_q == S_LEAD) || (state_q == S_EMIT);
    assign busy            = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done            = (state_q == S_DONE);
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_spigot_e_core.sv
// Directed bench for spigot_e_core: reset, full runs, latency, backpressure, ena stall, restart.
module tb_spigot_e_core;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena   = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic [2:0] dbg_state;

    spigot_e_if sif();

    spigot_e_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .dout      (sif),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

`ifdef SPIGOT_E_FAST_DIV_EN
    localparam int LAT = 62;
`else
    localparam int LAT = 155;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_digits [30] = '{2,7,1,8,2,8,1,8,2,8,4,5,9,0,4,5,2,3,5,3,6,0,2,8,7,4,7,1,3,5};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for a digit, check it and its latency, optionally stall it, then accept it.
    task automatic recv(input int idx, input int exp_lat, input int hold);
        int cnt;
        cnt = 0;
        sif.dout_ready = (hold == 0);
        while (!sif.dout_valid && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        check($sformatf("valid_d%0d", idx), 32'(sif.dout_valid), 1);
        check($sformatf("digit_d%0d", idx), 32'(sif.dout_digit), exp_digits[idx]);
        if (exp_lat >= 0) check($sformatf("lat_d%0d", idx), cnt, exp_lat);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check($sformatf("hold_valid_d%0d", idx), 32'(sif.dout_valid), 1);
            check($sformatf("hold_digit_d%0d", idx), 32'(sif.dout_digit), exp_digits[idx]);
        end
        sif.dout_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int w;
        sif.dout_ready = 1'b0;
        ena = 1'b1;

        // Asynchronous reset mid-cycle
        #3 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(sif.dout_valid), 0);
        check("rst_digit", 32'(sif.dout_digit), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_state", 32'(dbg_state), 0);
        check("idle_valid", 32'(sif.dout_valid), 0);
        check("idle_busy", 32'(busy), 0);

        // Basic run with the consumer always ready
        sif.dout_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 30; i++) recv(i, (i == 0) ? 0 : LAT, 0);
        check("run1_done", 32'(done), 1);
        check("run1_busy", 32'(busy), 0);
        check("run1_valid", 32'(sif.dout_valid), 0);

        // Restart from DONE: backpressure on 7, ena stall and ignored start on the 3rd digit
        pulse_start();
        check("run2_busy_lead", 32'(busy), 1);
        recv(0, 0, 0);
        recv(1, LAT, 20);
        repeat (2) @(negedge clk);
        check("run2_mid_div", 32'(dbg_state), 3);
        ena = 1'b0;
        repeat (10) @(negedge clk);
        check("run2_stall_busy", 32'(busy), 1);
        ena = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        recv(2, LAT + 10 - 13, 0);
        for (int i = 3; i < 30; i++) recv(i, LAT, 0);
        check("run2_done", 32'(done), 1);
        check("run2_busy", 32'(busy), 0);

        // Reset while the 6th digit is pending, then restart
        pulse_start();
        for (int i = 0; i < 5; i++) recv(i, (i == 0) ? 0 : LAT, 0);
        sif.dout_ready = 1'b0;
        w = 0;
        while (!sif.dout_valid && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("run3_pending_valid", 32'(sif.dout_valid), 1);
        check("run3_pending_digit", 32'(sif.dout_digit), exp_digits[5]);
        #2 rst_n = 1'b0;
        #1;
        check("run3_rst_valid", 32'(sif.dout_valid), 0);
        check("run3_rst_digit", 32'(sif.dout_digit), 0);
        check("run3_rst_busy", 32'(busy), 0);
        check("run3_rst_done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("run3_idle_state", 32'(dbg_state), 0);
        sif.dout_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 3; i++) recv(i, (i == 0) ? 0 : LAT, 0);
        check("run3_busy", 32'(busy), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
